multi_alarm_core: RTL and testbench

Parametrised successor to the single-register alarm path (alarm register plus display-driver ring/snooze logic). Holds `N_ALARMS` independent BCD HH:MM alarm registers, each with its own ring/snooze state machine, snooze countdown and ring auto-timeout. Compares against the clock counter's `current_time` and drives one merged `sound_alarm`. Sits between the controller (load pulses), the clock counter (time, `one_minute`) and the display mux (alarm readback).

---
 rtl/multi_alarm_core.sv | 159 +++++++++++++++
 tb/tb_multi_alarm_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_core.sv
// Purpose: N independent BCD HH:MM alarms, each with its own ring/snooze FSM, snooze countdown and ring timeout.
// Latency: a match, button or load in cycle t is visible on the outputs in cycle t+1; alarm_time_out is registered.
// Backpressure: none; all inputs are pulses or levels and are accepted every cycle.
module multi_alarm_core #(
  parameter int N_ALARMS         = 4,
  parameter int SEL_W            = 2,
  parameter int SNOOZE_MIN       = 10,
  parameter int RING_TIMEOUT_MIN = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                one_minute,
  input  logic [15:0]         current_time,
  input  logic [15:0]         alarm_time_in,
  input  logic [SEL_W-1:0]    alarm_sel,
  input  logic                load_alarm,
  input  logic [N_ALARMS-1:0] alarm_enable,
  input  logic                do_snooze,
  input  logic                stop_alarm,
  input  logic [SEL_W-1:0]    show_sel,
  output logic [15:0]         alarm_time_out,
  output logic [N_ALARMS-1:0] ringing,
  output logic [N_ALARMS-1:0] snoozing,
  output logic                sound_alarm
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [7:0] SNOOZE_CNT  = 8'(SNOOZE_MIN);
  localparam logic [7:0] TIMEOUT_CNT = 8'(RING_TIMEOUT_MIN);

  state_t      state_q [N_ALARMS];
  state_t      state_d [N_ALARMS];
  logic [7:0]  cnt_q   [N_ALARMS];
  logic [7:0]  cnt_d   [N_ALARMS];
  logic [15:0] alarm_q [N_ALARMS];
  logic [15:0] alarm_d [N_ALARMS];
  logic [15:0] time_q, time_d;
  logic        primed_q, primed_d;
  logic [15:0] aout_q, aout_d;
  logic        tchg;

  // Time-change detect: only a fresh change after the first post-reset clock can trigger a match.
  always_comb begin
    time_d   = current_time;
    primed_d = 1'b1;
    tchg     = primed_q && (current_time != time_q);
  end

  // Per-channel register write and FSM next state, highest-priority condition first.
  always_comb begin
    for (int i = 0; i < N_ALARMS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      alarm_d[i] = alarm_q[i];
      if (load_alarm && (alarm_sel == SEL_W'(i))) begin
        alarm_d[i] = alarm_time_in;
      end
      if (!alarm_enable[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = 8'd0;
      end else if (load_alarm && (alarm_sel == SEL_W'(i))) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = 8'd0;
      end else if (stop_alarm) begin
        // Also blocks a match arriving in the same cycle.
        state_d[i] = ST_IDLE;
        cnt_d[i]   = 8'd0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (tchg && (current_time == alarm_q[i])) begin
              state_d[i] = ST_RINGING;
              cnt_d[i]   = 8'd0;
            end
          end
          ST_RINGING: begin
            if (do_snooze) begin
              state_d[i] = ST_SNOOZE;
              cnt_d[i]   = SNOOZE_CNT;
            end else if (one_minute) begin
              cnt_d[i] = cnt_q[i] + 8'd1;
              if ((RING_TIMEOUT_MIN != 0) && ((cnt_q[i] + 8'd1) == TIMEOUT_CNT)) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = 8'd0;
              end
            end
          end
          ST_SNOOZE: begin
            // do_snooze and matches are deliberately ignored while snoozing.
            if (one_minute) begin
              if ((cnt_q[i] - 8'd1) == 8'd0) begin
                state_d[i] = ST_RINGING;
                cnt_d[i]   = 8'd0;
              end else begin
                cnt_d[i] = cnt_q[i] - 8'd1;
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  // Readback mux uses the next register value so a load shows up one cycle later.
  always_comb begin
    aout_d = 16'h0000;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (show_sel == SEL_W'(i)) begin
        aout_d = alarm_d[i];
      end
    end
  end

  // Per-channel status decode straight from the state registers.
  always_comb begin
    ringing  = '0;
    snoozing = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      ringing[i]  = (state_q[i] == ST_RINGING);
      snoozing[i] = (state_q[i] == ST_SNOOZE);
    end
  end

  assign sound_alarm    = |ringing;
  assign alarm_time_out = aout_q;

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 8'd0;
        alarm_q[i] <= 16'h0000;
      end
      time_q   <= 16'h0000;
      primed_q <= 1'b0;
      aout_q   <= 16'h0000;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        alarm_q[i] <= alarm_d[i];
      end
      time_q   <= time_d;
      primed_q <= primed_d;
      aout_q   <= aout_d;
    end
  end

endmodule

// File: tb/tb_multi_alarm_core.sv
// Purpose: directed scoreboard bench for multi_alarm_core (timeout-3 instance plus a no-timeout instance).
// Latency: inputs driven 1ns after posedge; outputs sampled on the following negedge.
// Backpressure: none; expectations are queued by stimulus and drained by the monitor.
module tb_multi_alarm_core;

  typedef struct packed {
    logic [3:0]  ra;
    logic [3:0]  sa;
    logic        snd;
    logic [15:0] ao;
    logic [3:0]  rb;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        one_minute;
  logic [15:0] current_time;
  logic [15:0] alarm_time_in;
  logic [2:0]  alarm_sel;
  logic        load_alarm;
  logic [3:0]  en_a;
  logic [3:0]  en_b;
  logic        do_snooze;
  logic        stop_alarm;
  logic [2:0]  show_sel;

  logic [15:0] aout_a, aout_b;
  logic [3:0]  ring_a, ring_b, snz_a, snz_b;
  logic        snd_a, snd_b;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  cur_e;
  string cur_n;
  logic  chk_vld;
  int    checks;
  int    failures;

  multi_alarm_core #(.N_ALARMS(4), .SEL_W(3), .SNOOZE_MIN(10), .RING_TIMEOUT_MIN(3)) u_dut_a (
    .clk(clk), .reset(reset), .one_minute(one_minute), .current_time(current_time),
    .alarm_time_in(alarm_time_in), .alarm_sel(alarm_sel), .load_alarm(load_alarm),
    .alarm_enable(en_a), .do_snooze(do_snooze), .stop_alarm(stop_alarm), .show_sel(show_sel),
    .alarm_time_out(aout_a), .ringing(ring_a), .snoozing(snz_a), .sound_alarm(snd_a)
  );

  multi_alarm_core #(.N_ALARMS(4), .SEL_W(3), .SNOOZE_MIN(10), .RING_TIMEOUT_MIN(0)) u_dut_b (
    .clk(clk), .reset(reset), .one_minute(one_minute), .current_time(current_time),
    .alarm_time_in(alarm_time_in), .alarm_sel(alarm_sel), .load_alarm(load_alarm),
    .alarm_enable(en_b), .do_snooze(do_snooze), .stop_alarm(stop_alarm), .show_sel(show_sel),
    .alarm_time_out(aout_b), .ringing(ring_b), .snoozing(snz_b), .sound_alarm(snd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain every queued expectation when a response is flagged.
  always @(negedge clk) begin
    if (chk_vld) begin
      while (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        cur_n = name_q.pop_front();
        checks++;
        if ({ring_a, snz_a, snd_a, aout_a, ring_b} !== cur_e) begin
          failures++;
          $display("FAIL %s: got ring=%b snz=%b snd=%b aout=%h ring_b=%b, expected ring=%b snz=%b snd=%b aout=%h ring_b=%b",
                   cur_n, ring_a, snz_a, snd_a, aout_a, ring_b,
                   cur_e.ra, cur_e.sa, cur_e.snd, cur_e.ao, cur_e.rb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string n, input logic [3:0] ra, input logic [3:0] sa,
                       input logic [15:0] ao, input logic [3:0] rb);
    exp_t e;
    e.ra  = ra;
    e.sa  = sa;
    e.snd = |ra;
    e.ao  = ao;
    e.rb  = rb;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_vld = 1'b1;
  endtask

  task automatic load(input logic [2:0] sel, input logic [15:0] val);
    alarm_sel     = sel;
    alarm_time_in = val;
    load_alarm    = 1'b1;
    tick();
    load_alarm    = 1'b0;
  endtask

  task automatic minute();
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp);
    do_snooze  = snz;
    stop_alarm = stp;
    tick();
    do_snooze  = 1'b0;
    stop_alarm = 1'b0;
  endtask

  task automatic set_time(input logic [15:0] t);
    current_time = t;
    tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    chk_vld       = 1'b0;
    reset         = 1'b0;
    one_minute    = 1'b0;
    current_time  = 16'h0000;
    alarm_time_in = 16'h0000;
    alarm_sel     = 3'd0;
    load_alarm    = 1'b0;
    en_a          = 4'b0000;
    en_b          = 4'b0000;
    do_snooze     = 1'b0;
    stop_alarm    = 1'b0;
    show_sel      = 3'd0;

    ticks(3);
    check("reset_state", 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    reset = 1'b1;
    ticks(2);

    // Two channels on the same time ring together; stop clears both.
    load(3'd0, 16'h0630);
    check("load0_readback", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    load(3'd2, 16'h0630);
    show_sel = 3'd2; tick();
    check("show2", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    show_sel = 3'd1; tick();
    check("show1_empty", 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    show_sel = 3'd0; tick();
    en_a = 4'b0101;
    set_time(16'h0629);
    set_time(16'h0630);
    check("match_0101", 4'b0101, 4'b0000, 16'h0630, 4'b0000);
    ticks(3);
    check("hold_ringing", 4'b0101, 4'b0000, 16'h0630, 4'b0000);
    press(1'b0, 1'b1);
    check("stop_all", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    ticks(3);
    check("no_retrigger", 4'b0000, 4'b0000, 16'h0630, 4'b0000);

    // Snooze length, then ring timeout (A: 3 minutes, B: disabled).
    en_a = 4'b0010;
    en_b = 4'b0010;
    load(3'd1, 16'h0700);
    set_time(16'h0700);
    check("match_ch1", 4'b0010, 4'b0000, 16'h0630, 4'b0010);
    press(1'b1, 1'b0);
    check("snooze_ch1", 4'b0000, 4'b0010, 16'h0630, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      minute();
      tick();
    end
    check("snooze_after_9", 4'b0000, 4'b0010, 16'h0630, 4'b0000);
    minute();
    check("snooze_after_10", 4'b0010, 4'b0000, 16'h0630, 4'b0010);
    tick();
    minute(); tick();
    minute();
    check("timeout_after_2", 4'b0010, 4'b0000, 16'h0630, 4'b0010);
    tick();
    minute();
    check("timeout_after_3", 4'b0000, 4'b0000, 16'h0630, 4'b0010);
    for (int k = 0; k < 297; k++) begin
      tick();
      minute();
    end
    check("no_timeout_300", 4'b0000, 4'b0000, 16'h0630, 4'b0010);
    press(1'b0, 1'b1);
    check("stop_b", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    en_b = 4'b0000;

    // Stop beats snooze; stop beats a same-cycle match.
    set_time(16'h0659);
    set_time(16'h0700);
    check("rematch_ch1", 4'b0010, 4'b0000, 16'h0630, 4'b0000);
    press(1'b1, 1'b1);
    check("snooze_stop_idle", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    set_time(16'h0659);
    current_time = 16'h0700;
    press(1'b0, 1'b1);
    check("match_with_stop", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    tick();
    check("match_with_stop_held", 4'b0000, 4'b0000, 16'h0630, 4'b0000);

    // Disable while snoozing; out-of-range load and readback.
    load(3'd3, 16'h0800);
    en_a = 4'b1000;
    set_time(16'h0800);
    check("match_ch3", 4'b1000, 4'b0000, 16'h0630, 4'b0000);
    press(1'b1, 1'b0);
    check("snooze_ch3", 4'b0000, 4'b1000, 16'h0630, 4'b0000);
    en_a = 4'b0000;
    tick();
    check("enable_drop", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    load(3'd5, 16'h1234);
    show_sel = 3'd0; tick();
    check("regs_ch0", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    show_sel = 3'd1; tick();
    check("regs_ch1", 4'b0000, 4'b0000, 16'h0700, 4'b0000);
    show_sel = 3'd2; tick();
    check("regs_ch2", 4'b0000, 4'b0000, 16'h0630, 4'b0000);
    show_sel = 3'd3; tick();
    check("regs_ch3", 4'b0000, 4'b0000, 16'h0800, 4'b0000);
    show_sel = 3'd5; tick();
    check("show_out_of_range", 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    show_sel = 3'd0; tick();

    // Static time after reset never rings; async reset mid-ring.
    reset = 1'b0;
    current_time = 16'h1200;
    tick();
    reset = 1'b1;
    tick();
    check("reset_clears", 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    load(3'd0, 16'h1200);
    en_a = 4'b0001;
    ticks(5);
    check("static_after_reset", 4'b0000, 4'b0000, 16'h1200, 4'b0000);
    set_time(16'h1159);
    set_time(16'h1200);
    check("ring_before_reset", 4'b0001, 4'b0000, 16'h1200, 4'b0000);
    tick();
    #2;
    reset = 1'b0;
    check("async_reset", 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
